wptr_full: RTL and testbench

WPTR_FULL -- requirements
Module: wptr_full

---
 rtl/wptr_full_pkg.sv | 12 +
 rtl/wptr_full_gray2bin.sv | 17 +
 rtl/wptr_full.sv | 80 ++++++++
 tb/tb_wptr_full.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/wptr_full_pkg.sv
// Shared FIFO defaults: pointer width, almost-full threshold and depth derivation.
// Both the write-side and read-side pointer blocks import this package.
package wptr_full_pkg;

  localparam int FIFO_ADDR_WIDTH   = 4;
  localparam int FIFO_AFULL_THRESH = 2;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/wptr_full_gray2bin.sv
// Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
// Reused by the read-side pointer block.
module gray2bin #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  always_comb begin
    bin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and status block of an async FIFO: binary/Gray write pointer,
// registered full / almost-full / level flags and a sticky overflow error.
module wptr_full
  import wptr_full_pkg::*;
#(
  parameter int ADDR_WIDTH   = FIFO_ADDR_WIDTH,
  parameter int AFULL_THRESH = FIFO_AFULL_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rq2_rgray,
  output logic                  wmem_en,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wgray,
  output logic                  wfull,
  output logic                  walmost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  wovf
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);
  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  localparam logic [PW-1:0] FULL_MASK   = PW'(3) << (PW - 2);

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          walmost_full_q, walmost_full_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] rbin_s;

  gray2bin #(
    .WIDTH (PW)
  ) u_rgray2bin (
    .gray (rq2_rgray),
    .bin  (rbin_s)
  );

  assign wmem_en = wr_en & ~wfull_q;

  always_comb begin
    wbin_d         = wbin_q + PW'(wmem_en);
    wgray_d        = wbin_d ^ (wbin_d >> 1);
    wfull_d        = (wgray_d == (rq2_rgray ^ FULL_MASK));
    wlevel_d       = wbin_d - rbin_s;
    walmost_full_d = (wlevel_d >= AFULL_LEVEL);
    wovf_d         = wovf_q | (wr_en & wfull_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q         <= '0;
      wgray_q        <= '0;
      wlevel_q       <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wovf_q         <= 1'b0;
    end else begin
      wbin_q         <= wbin_d;
      wgray_q        <= wgray_d;
      wlevel_q       <= wlevel_d;
      wfull_q        <= wfull_d;
      walmost_full_q <= walmost_full_d;
      wovf_q         <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDR_WIDTH-1:0];
  assign wgray        = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = walmost_full_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full (ADDR_WIDTH=4, AFULL_THRESH=2): directed scenarios
// plus randomized traffic compared every cycle against a write/read-count model.
module tb_wptr_full;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int PMOD  = 32;
  localparam int THR   = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW:0]   rq2_rgray = '0;
  logic          wmem_en;
  logic [AW-1:0] waddr;
  logic [AW:0]   wgray;
  logic          wfull;
  logic          walmost_full;
  logic [AW:0]   wlevel;
  logic          wovf;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: total accepted writes and read count, both modulo 2*DEPTH.
  int rd_cnt  = 0;
  int m_wcnt  = 0;
  int m_level = 0;
  bit m_full  = 0;
  bit m_almost = 0;
  bit m_ovf   = 0;

  bit          full_seen = 0;
  bit          prev_valid = 0;
  logic [AW:0] prev_wgray = '0;

  wptr_full #(
    .ADDR_WIDTH   (AW),
    .AFULL_THRESH (THR)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .rq2_rgray    (rq2_rgray),
    .wmem_en      (wmem_en),
    .waddr        (waddr),
    .wgray        (wgray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wovf         (wovf)
  );

  always #5 clk = ~clk;

  function automatic logic [AW:0] to_gray(input int n);
    int v;
    v = n % PMOD;
    return (AW+1)'(v ^ (v >> 1));
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference behaviour: a write is accepted only when not already full.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wcnt = 0; m_level = 0; m_full = 0; m_almost = 0; m_ovf = 0;
    end else begin
      if (wr_en && m_full) m_ovf = 1;
      if (wr_en && !m_full) m_wcnt = (m_wcnt + 1) % PMOD;
      m_level  = ((m_wcnt - rd_cnt) % PMOD + PMOD) % PMOD;
      m_full   = (m_level == DEPTH);
      m_almost = (m_level >= DEPTH - THR);
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 0;
    end else begin
      checkOutput("wgray",        int'(wgray),        int'(to_gray(m_wcnt)));
      checkOutput("waddr",        int'(waddr),        m_wcnt % DEPTH);
      checkOutput("wlevel",       int'(wlevel),       m_level);
      checkOutput("wfull",        int'(wfull),        int'(m_full));
      checkOutput("walmost_full", int'(walmost_full), int'(m_almost));
      checkOutput("wovf",         int'(wovf),         int'(m_ovf));
      checkOutput("wmem_en",      int'(wmem_en),      int'(wr_en && !m_full));
      if (prev_valid)
        checkOutput("wgray_one_bit_step", int'($countones(wgray ^ prev_wgray) <= 1), 1);
      if (wfull) full_seen = 1;
      prev_wgray = wgray;
      prev_valid = 1;
    end
  end

  // Drives inputs for the next rising edge, then returns 2 time units after it.
  task automatic applyStimulus(input logic w, input int r);
    wr_en     = w;
    rd_cnt    = r % PMOD;
    rq2_rgray = to_gray(rd_cnt);
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst_n = 1'b0; wr_en = 1'b0; rd_cnt = 0; rq2_rgray = '0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int r;
    bit w;
    int wprob;

    doReset();
    checkOutput("reset_wgray",  int'(wgray),  0);
    checkOutput("reset_wlevel", int'(wlevel), 0);
    checkOutput("reset_wfull",  int'(wfull),  0);

    // Fill to full, then overflow, then one read frees a slot.
    repeat (DEPTH) applyStimulus(1'b1, 0);
    checkOutput("fill_wfull",  int'(wfull),  1);
    checkOutput("fill_wgray",  int'(wgray),  'b11000);
    checkOutput("fill_waddr",  int'(waddr),  0);
    checkOutput("fill_wlevel", int'(wlevel), 16);
    wr_en = 1'b1;
    #1;
    checkOutput("ovf_wmem_en", int'(wmem_en), 0);
    applyStimulus(1'b1, 0);
    checkOutput("ovf_wovf",  int'(wovf),  1);
    checkOutput("ovf_wgray", int'(wgray), 'b11000);
    applyStimulus(1'b0, 1);
    checkOutput("drain_wfull",  int'(wfull),        0);
    checkOutput("drain_wlevel", int'(wlevel),       15);
    checkOutput("drain_afull",  int'(walmost_full), 1);

    // Almost-full threshold boundary.
    doReset();
    repeat (13) applyStimulus(1'b1, 0);
    checkOutput("afull_13",  int'(walmost_full), 0);
    checkOutput("level_13",  int'(wlevel),       13);
    applyStimulus(1'b1, 0);
    checkOutput("afull_14",  int'(walmost_full), 1);
    checkOutput("level_14",  int'(wlevel),       14);

    // Full pointer wrap with the read side trailing by two cycles.
    doReset();
    full_seen = 0;
    for (int i = 0; i < 2 * DEPTH; i++) applyStimulus(1'b1, (i >= 2) ? i - 2 : 0);
    checkOutput("wrap_wgray",     int'(wgray), 0);
    checkOutput("wrap_waddr",     int'(waddr), 0);
    checkOutput("wrap_full_seen", int'(full_seen), 0);

    // Asynchronous reset between clock edges.
    doReset();
    repeat (5) applyStimulus(1'b1, 0);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_wgray",  int'(wgray),        0);
    checkOutput("async_waddr",  int'(waddr),        0);
    checkOutput("async_wlevel", int'(wlevel),       0);
    checkOutput("async_wfull",  int'(wfull),        0);
    checkOutput("async_afull",  int'(walmost_full), 0);
    checkOutput("async_wovf",   int'(wovf),         0);
    wr_en = 1'b0; rd_cnt = 0; rq2_rgray = '0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) applyStimulus(1'b1, 0);
    checkOutput("resume_waddr", int'(waddr), 3);

    // Randomized traffic at several write intensities.
    doReset();
    r = 0;
    for (int p = 0; p < 3; p++) begin
      wprob = (p == 0) ? 3 : (p == 1) ? 1 : 2;
      for (int c = 0; c < 400; c++) begin
        w = ($urandom_range(3) < wprob);
        if (m_level > 0 && $urandom_range(2) == 0) r = r + 1;
        applyStimulus(w, r);
      end
    end

    wr_en = 1'b0;
    @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
